// File: rtl/day_counter.sv
// Day-of-month stage of the calendar clock: advances on end-of-day or a day-button
// press, wraps at the month length, clamps stale days, and carries into the month stage.
module day_counter #(
  parameter int YEAR_W    = 7,
  parameter int RESET_DAY = 1
) (
  input  logic              sig_1Hz,
  input  logic              reset,
  input  logic              end_day,
  input  logic              day_b,
  input  logic [3:0]        month,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        day_o,
  output logic              end_month,
  output logic [4:0]        last_day
);

  localparam logic [4:0] RESET_DAY_V = 5'(RESET_DAY);

  logic [4:0] day;
  logic [4:0] day_nxt;
  logic       btn_q;
  logic       run_q;
  logic       btn_rise;
  logic       inc;

  always_comb begin
    last_day = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: last_day = 5'd30;
      4'd2:                    last_day = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 last_day = 5'd31;
    endcase
  end

  // run_q masks the first clock after reset release, so a press held through
  // reset (history cleared to 0) is not mistaken for a fresh press.
  assign btn_rise = day_b & ~btn_q & run_q;
  assign inc      = end_day | btn_rise;

  always_comb begin
    day_nxt = day;
    if (inc && (day >= last_day)) begin
      day_nxt = 5'd1;
    end else if (inc) begin
      day_nxt = day + 5'd1;
    end else if (day > last_day) begin
      day_nxt = last_day;
    end
  end

  always_ff @(posedge sig_1Hz) begin
    if (!reset) begin
      day   <= RESET_DAY_V;
      btn_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      day   <= day_nxt;
      btn_q <= day_b;
      run_q <= 1'b1;
    end
  end

  assign end_month = end_day & (day == last_day);
  assign day_o     = day;

endmodule

// File: tb/tb_day_counter.sv
// Scoreboard bench for day_counter: stimulus pushes calendar-model expectations,
// a monitor pops them and compares last_day/end_month before the edge and day_o after it.
module tb_day_counter;

  localparam int YEAR_W    = 7;
  localparam int RESET_DAY = 1;

  logic              clk;
  logic              reset;
  logic              end_day;
  logic              day_b;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic [4:0]        day_o;
  logic              end_month;
  logic [4:0]        last_day;

  day_counter #(.YEAR_W(YEAR_W), .RESET_DAY(RESET_DAY)) dut (
    .sig_1Hz  (clk),
    .reset    (reset),
    .end_day  (end_day),
    .day_b    (day_b),
    .month    (month),
    .year     (year),
    .day_o    (day_o),
    .end_month(end_month),
    .last_day (last_day)
  );

  typedef struct {
    int ld;
    bit em;
    int day;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  // calendar model state
  int m_day    = RESET_DAY;
  bit m_prev   = 0;
  bit m_armed  = 0;
  int cur_mo   = 1;
  int cur_yr   = 23;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int month_len(int mo, int yr);
    int tab[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 31;
    if (mo == 2 && (yr % 4) == 0) return 29;
    return tab[mo-1];
  endfunction

  task automatic step(input bit r, input bit e, input bit b, input int mo, input int yr);
    exp_t x;
    int   ld;
    bit   press;
    @(negedge clk);
    reset   = r;
    end_day = e;
    day_b   = b;
    month   = 4'(mo);
    year    = YEAR_W'(yr);
    ld      = month_len(mo, yr);
    x.ld    = ld;
    x.em    = e && (m_day == ld);
    if (!r) begin
      m_day   = RESET_DAY;
      m_prev  = 0;
      m_armed = 0;
    end else begin
      press = b && !m_prev && m_armed;
      if (e || press) m_day = (m_day >= ld) ? 1 : m_day + 1;
      else if (m_day > ld) m_day = ld;
      m_prev  = b;
      m_armed = 1;
    end
    x.day = m_day;
    exp_q.push_back(x);
  endtask

  task automatic press(input int mo, input int yr);
    step(1, 0, 1, mo, yr);
    step(1, 0, 0, mo, yr);
  endtask

  task automatic set_day(input int target, input int mo, input int yr);
    for (int i = 0; i < 64 && m_day != target; i++) press(mo, yr);
  endtask

  // monitor
  initial begin
    exp_t x;
    int   a_ld;
    bit   a_em;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() == 0) continue;
      x    = exp_q.pop_front();
      a_ld = int'(last_day);
      a_em = end_month;
      checks++;
      if (a_ld != x.ld) begin
        failures++;
        $display("FAIL last_day: got %0d expected %0d at %0t", a_ld, x.ld, $time);
      end
      checks++;
      if (a_em != x.em) begin
        failures++;
        $display("FAIL end_month: got %0d expected %0d at %0t", a_em, x.em, $time);
      end
      @(posedge clk);
      #1;
      checks++;
      if (int'(day_o) != x.day) begin
        failures++;
        $display("FAIL day_o: got %0d expected %0d at %0t", day_o, x.day, $time);
      end
    end
  end

  initial begin
    int mo;
    int yr;
    reset   = 1'b0;
    end_day = 1'b0;
    day_b   = 1'b1;
    month   = 4'd1;
    year    = YEAR_W'(23);

    // reset held with button pressed, then release while still held
    step(0, 0, 1, 1, 23);
    step(0, 0, 1, 1, 23);
    step(1, 0, 1, 1, 23);
    step(1, 0, 1, 1, 23);
    step(1, 0, 0, 1, 23);

    // 30-day month end
    set_day(30, 4, 23);
    step(1, 1, 0, 4, 23);
    step(1, 0, 0, 4, 23);

    // day 30 in a 31-day month
    set_day(30, 5, 23);
    step(1, 1, 0, 5, 23);

    // leap February
    set_day(28, 2, 24);
    step(1, 1, 0, 2, 24);
    step(1, 1, 0, 2, 24);

    // non-leap February
    set_day(28, 2, 23);
    step(1, 1, 0, 2, 23);

    // long press at day 31 wraps once, no carry
    set_day(31, 1, 23);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 23);
    step(1, 0, 0, 1, 23);

    // clamp after month change
    set_day(31, 1, 23);
    step(1, 0, 0, 2, 23);
    step(1, 0, 0, 2, 23);

    // stale day meets end_day: wrap without carry
    set_day(31, 1, 23);
    step(1, 1, 0, 4, 23);

    // simultaneous end_day and button rise
    set_day(10, 1, 23);
    step(1, 1, 1, 1, 23);
    step(1, 0, 0, 1, 23);

    // out-of-range month
    step(1, 0, 0, 0, 23);
    step(1, 0, 0, 13, 23);
    step(1, 0, 0, 15, 23);

    // randomized traffic
    mo = 1;
    yr = 23;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        mo = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : int'($urandom_range(12, 1));
        yr = int'($urandom_range(99));
      end
      step(($urandom_range(59) != 0), ($urandom_range(3) == 0), bit'($urandom_range(1)), mo, yr);
    end

    step(1, 0, 0, mo, yr);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/day_counter.md
Name: day_counter

Overview:
- Day-of-month counter for the digital calendar clock, one stage upstream of the month counter.
- Consumes the end-of-day event from the hour stage and the current month/year.
- Produces the day value and the end-of-month carry that the month stage uses to advance the month.
- Handles the number of days per month, leap years, a manual day-set button and clamping when the month changes under a too-large day.

Parameters:
- YEAR_W, 7, width of year input: two-digit year offset from 2000, valid 0..99.
- RESET_DAY, 1, day value loaded on reset, legal 1..28.

Ports:
- sig_1Hz  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of sig_1Hz.
- end_day  input  1  level, high for exactly the clock in which the hour stage rolls 23:59:59 to 00:00:00.
- day_b  input  1  raw day-increment button level, already debounced, high while pressed.
- month  input  4  current month 1..12 from the month stage.
- year  input  YEAR_W  current year offset (2000 + year).
- day_o  output  5  current day of month, 1..31.
- end_month  output  1  combinational carry to the month stage.
- last_day  output  5  combinational number of days in the current month.

Behaviour:
- Reset: when reset==0 at a rising edge, day <= RESET_DAY and the button history register <= 0; this overrides every other event.
- last_day (combinational):
  - month 4, 6, 9, 11 -> 30.
  - month 2 -> 29 if year[1:0]==0, else 28.
  - all other months -> 31.
  - out-of-range month (0, 13..15) -> 31.
- Button edge detect:
  - btn_q <= day_b every clock.
  - btn_rise = day_b & ~btn_q.
  - One increment per press regardless of hold length.
  - A press held through reset does not produce an increment on the first clock after reset release.
- Increment request: inc = end_day | btn_rise. Simultaneous end_day and btn_rise give a single increment, not two.
- Next-day rule, priority order each clock, applied when reset==1:
  1. If inc and day >= last_day -> day <= 1.
  2. Else if inc -> day <= day + 1.
  3. Else if day > last_day -> day <= last_day. This clamps, e.g. day 31 when month changes to 4 gives 30 one clock later.
  4. Else hold.
- end_month = end_day & (day == last_day), combinational from the current registered day.
  - Asserted in the same clock as end_day, so the month stage advances on the same edge that day wraps to 1.
  - A button wrap (btn_rise only) never asserts end_month. Setting the day does not carry into the month.
- Wrap when day > last_day and end_day arrives (stale day after a month change): day <= 1. end_month stays 0 because day != last_day.
- Day 0 is never produced. If day is somehow 0, treat it as < last_day and increment normally.
- day_o = day register. Latency is 1 clock from inc to the updated day_o.
- All arithmetic is 5-bit unsigned. No overflow is possible since day <= 31.

Test Plan:
- Reset: hold reset=0 for 2 clocks with day_b=1, then release -> day_o=1 (RESET_DAY) and no increment on the first post-reset clock while day_b stays 1.
- Month end, 30-day month: month=4, day=30, end_day pulse -> end_month=1 in that clock; next clock day_o=1.
- Same day at 31-day month: month=5, day=30, end_day pulse -> end_month=0, day_o=31.
- Leap year February: month=2, year=24, day=28, end_day -> day_o=29, end_month=0. Then end_day again -> end_month=1, day_o=1.
- Non-leap February: month=2, year=23, day=28, end_day -> end_month=1, day_o=1.
- Button and clamp:
  - month=1, day=31, press day_b for 5 clocks -> day_o=1 after exactly one increment, end_month=0.
  - Then set day to 31, change month to 2 with year=23 -> day_o=28 one clock later.
  - Simultaneous end_day and btn_rise at day=10 -> day_o=11.
